// File: rtl/sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter
//   Shares one sram-like master port (toward the AXI bridge) between the
//   instruction fetch path and the data path. The FSM keeps exactly one
//   transaction outstanding on m_*.
//
//   Arbitration policy:
//   - Data requests normally win over instruction requests.
//   - STARVE_LIMIT caps how many data grants can be taken in a row while
//     an instruction request is waiting.
//
// Parameters
//   STARVE_LIMIT   Max consecutive data grants while inst_req pends (1..15).
//
// Ports
//   aclk, aresetn        Clock and asynchronous active-low reset.
//   inst_*               I-side request: req/wr/size/addr/wdata in,
//                        rdata/addr_ok/data_ok out.
//   data_*               D-side request: req/wr/wen/size/addr/wdata in,
//                        rdata/addr_ok/data_ok out.
//   m_*                  Shared sram-like port: req/wr/wen/size/addr/wdata
//                        out, rdata/addr_ok/data_ok in.
//   busy                 High whenever a transaction is in flight.
//   grant                One-hot {data,inst} owner of the shared port.
// ---------------------------------------------------------------------------
module sram_like_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wen,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        m_req,
    output logic        m_wr,
    output logic [3:0]  m_wen,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,

    output logic        busy,
    output logic [1:0]  grant
);

    typedef enum logic [2:0] {
        IDLE,
        I_ADDR,
        I_DATA,
        D_ADDR,
        D_DATA
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;
    // Held low for the first edge after reset release, so the earliest
    // possible grant lands on the second rising edge.
    logic       arb_en;

    // Read data is broadcast; each master qualifies it with its own data_ok.
    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            arb_en     <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            arb_en     <= 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        busy           = 1'b1;
        grant          = 2'b00;
        m_req          = 1'b0;
        m_wr           = 1'b0;
        m_wen          = 4'h0;
        m_size         = 2'd0;
        m_addr         = 32'd0;
        m_wdata        = 32'd0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        data_addr_ok   = 1'b0;
        data_data_ok   = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (arb_en) begin
                    if (data_req && (!inst_req || (starve_cnt < LIMIT))) begin
                        state_nxt = D_ADDR;
                        if (inst_req && (starve_cnt != 4'hF)) begin
                            starve_cnt_nxt = starve_cnt + 4'd1;
                        end
                    end else if (inst_req) begin
                        state_nxt      = I_ADDR;
                        starve_cnt_nxt = 4'd0;
                    end
                end
            end

            I_ADDR: begin
                grant        = 2'b01;
                m_req        = 1'b1;
                m_wr         = inst_wr;
                m_wen        = inst_wr ? 4'hF : 4'h0;
                m_size       = inst_size;
                m_addr       = inst_addr;
                m_wdata      = inst_wdata;
                inst_addr_ok = m_addr_ok;
                // An accepted address must be followed to completion even if
                // the master lowers req in the same cycle.
                if (m_addr_ok) begin
                    state_nxt = I_DATA;
                end else if (!inst_req) begin
                    state_nxt = IDLE;
                end
            end

            I_DATA: begin
                grant        = 2'b01;
                inst_data_ok = m_data_ok;
                if (m_data_ok) begin
                    state_nxt = IDLE;
                end
            end

            D_ADDR: begin
                grant        = 2'b10;
                m_req        = 1'b1;
                m_wr         = data_wr;
                m_wen        = data_wen;
                m_size       = data_size;
                m_addr       = data_addr;
                m_wdata      = data_wdata;
                data_addr_ok = m_addr_ok;
                if (m_addr_ok) begin
                    state_nxt = D_DATA;
                end else if (!data_req) begin
                    state_nxt = IDLE;
                end
            end

            D_DATA: begin
                grant        = 2'b10;
                data_data_ok = m_data_ok;
                if (m_data_ok) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_like_arbiter
//   Directed bench for sram_like_arbiter (STARVE_LIMIT = 4). The bench plays
//   both masters and the slave directly, one step per clock cycle. Inputs
//   change 1 time unit after the rising edge; outputs are checked 1 unit
//   later, well clear of either clock edge.
// ---------------------------------------------------------------------------
module tb_sram_like_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [3:0]  data_wen;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        m_req, m_wr;
    logic [3:0]  m_wen;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_addr_ok, m_data_ok;
    logic        busy;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_err = 0;

    // Starvation run, ticks 1..15: expected grant and data_data_ok.
    logic [1:0] sg [15] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00,
                            2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00,
                            2'b01, 2'b01, 2'b00};
    logic       sd [15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                            1'b0, 1'b0, 1'b0};
    // Back-to-back inst reads, ticks 1..6.
    logic       bq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       bd [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    sram_like_arbiter #(.STARVE_LIMIT(4)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wen     (data_wen),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_wen        (m_wen),
        .m_size       (m_size),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .busy         (busy),
        .grant        (grant)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn    = 1'b0;
        inst_req   = 1'b1;
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_addr  = 32'hBFC0_0000;
        inst_wdata = 32'h1111_2222;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wen   = 4'h0;
        data_size  = 2'd0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        m_rdata    = 32'hCAFE_0001;
        m_addr_ok  = 1'b0;
        m_data_ok  = 1'b0;

        // Reset state before any clock edge
        #2;
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_mreq",  32'(m_req), 32'd0);
        chk("rst_iaok",  32'(inst_addr_ok), 32'd0);
        tick();
        tick();
        aresetn = 1'b1;
        #1;
        chk("rel_grant", 32'(grant), 32'd0);
        // First edge after release: no grant yet
        tick();
        chk("edge1_grant", 32'(grant), 32'd0);
        chk("edge1_mreq",  32'(m_req), 32'd0);
        chk("idle_maddr",  m_addr,  32'd0);
        chk("idle_mwdata", m_wdata, 32'd0);
        // Second edge: inst granted
        tick();
        #1;
        chk("a_grant", 32'(grant), 32'd1);
        chk("a_mreq",  32'(m_req), 32'd1);
        chk("a_maddr", m_addr, 32'hBFC0_0000);
        chk("a_mwen",  32'(m_wen), 32'd0);
        chk("a_msize", 32'(m_size), 32'd2);
        chk("a_busy",  32'(busy), 32'd1);
        chk("a_iaok0", 32'(inst_addr_ok), 32'd0);
        tick();
        tick();
        m_addr_ok = 1'b1;
        #1;
        chk("a_iaok1", 32'(inst_addr_ok), 32'd1);
        chk("a_daok",  32'(data_addr_ok), 32'd0);
        tick();
        m_addr_ok = 1'b0;
        inst_req  = 1'b0;
        #1;
        chk("a_data_mreq",  32'(m_req), 32'd0);
        chk("a_data_maddr", m_addr, 32'd0);
        chk("a_data_grant", 32'(grant), 32'd1);
        tick();
        tick();
        m_data_ok = 1'b1;
        m_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("a_idok",   32'(inst_data_ok), 32'd1);
        chk("a_irdata", inst_rdata, 32'hDEAD_BEEF);
        chk("a_ddok",   32'(data_data_ok), 32'd0);
        tick();
        m_data_ok = 1'b0;
        #1;
        chk("a_end_busy", 32'(busy), 32'd0);
        chk("a_end_idok", 32'(inst_data_ok), 32'd0);

        // Simultaneous requests: data wins
        inst_req   = 1'b1;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wen   = 4'b0011;
        data_size  = 2'd2;
        data_addr  = 32'h8000_1000;
        data_wdata = 32'h1234_5678;
        #1;
        chk("b_bubble", 32'(m_req), 32'd0);
        tick();
        m_addr_ok = 1'b1;
        #1;
        chk("b_grant",  32'(grant), 32'd2);
        chk("b_mwen",   32'(m_wen), 32'd3);
        chk("b_mwr",    32'(m_wr), 32'd1);
        chk("b_maddr",  m_addr, 32'h8000_1000);
        chk("b_mwdata", m_wdata, 32'h1234_5678);
        chk("b_daok",   32'(data_addr_ok), 32'd1);
        chk("b_iaok",   32'(inst_addr_ok), 32'd0);
        tick();
        data_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        #1;
        chk("b_ddok", 32'(data_data_ok), 32'd1);
        chk("b_idok", 32'(inst_data_ok), 32'd0);
        tick();
        m_data_ok = 1'b0;
        #1;
        chk("b_idle_grant", 32'(grant), 32'd0);
        tick();
        inst_wr = 1'b1;
        #1;
        chk("b_inst_grant", 32'(grant), 32'd1);
        chk("b_starve0",    32'(dut.starve_cnt), 32'd0);
        chk("b_iwr_mwen",   32'(m_wen), 32'hF);
        chk("b_iwr_mwr",    32'(m_wr), 32'd1);
        m_addr_ok = 1'b1;
        tick();
        inst_req  = 1'b0;
        inst_wr   = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        #1;
        chk("b_iw_idok", 32'(inst_data_ok), 32'd1);
        tick();

        // Stray m_data_ok in IDLE, then starvation with a always-ready slave
        data_wr   = 1'b0;
        data_req  = 1'b1;
        inst_req  = 1'b1;
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        #1;
        chk("c_idle_idok", 32'(inst_data_ok), 32'd0);
        chk("c_idle_ddok", 32'(data_data_ok), 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("c_grant%0d", i + 1), 32'(grant), 32'(sg[i]));
            chk($sformatf("c_ddok%0d", i + 1), 32'(data_data_ok), 32'(sd[i]));
            if (i == 11) chk("c_starve4", 32'(dut.starve_cnt), 32'd4);
            if (i == 12) chk("c_starve_clr", 32'(dut.starve_cnt), 32'd0);
        end

        // Abort: data_req drops in D_ADDR without m_addr_ok
        tick();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        data_req  = 1'b0;
        inst_req  = 1'b0;
        #1;
        chk("d_grant",  32'(grant), 32'd2);
        chk("d_starve", 32'(dut.starve_cnt), 32'd1);
        chk("d_daok",   32'(data_addr_ok), 32'd0);
        tick();
        chk("d_mreq", 32'(m_req), 32'd0);
        chk("d_busy", 32'(busy), 32'd0);

        // Reset in the middle of D_DATA
        data_req = 1'b1;
        tick();
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        data_req  = 1'b0;
        #1;
        chk("e_busy_pre", 32'(busy), 32'd1);
        #1;
        aresetn = 1'b0;
        #1;
        chk("e_busy_rst",  32'(busy), 32'd0);
        chk("e_grant_rst", 32'(grant), 32'd0);
        aresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            m_data_ok = 1'b1;
            #1;
            chk("e_ddok", 32'(data_data_ok), 32'd0);
            chk("e_idok", 32'(inst_data_ok), 32'd0);
            chk("e_busy", 32'(busy), 32'd0);
        end

        // Back-to-back inst reads, zero-latency slave
        inst_req  = 1'b1;
        m_addr_ok = 1'b1;
        m_rdata   = 32'h0BAD_F00D;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("f_iaok%0d", i + 1), 32'(inst_addr_ok), 32'(bq[i]));
            chk($sformatf("f_mreq%0d", i + 1), 32'(m_req), 32'(bq[i]));
            chk($sformatf("f_idok%0d", i + 1), 32'(inst_data_ok), 32'(bd[i]));
        end
        chk("f_drdata", data_rdata, 32'h0BAD_F00D);
        inst_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        tick();
        chk("f_end_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
